// File: rtl/wb_regfile_stage_if.sv
// Trace drain port of the write-back stage: valid/ready handshake carrying {rd, value}.
interface wb_regfile_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                     trace_valid;
   logic                     trace_ready;
   logic                     trace_full;
   logic [ADDR_W+DATA_W-1:0] trace_data;

   modport master (output trace_valid, trace_data, trace_full, input trace_ready);
   modport slave  (input trace_valid, trace_data, trace_full, output trace_ready);
endinterface

// File: rtl/wb_regfile_stage.sv
// Write-back stage: commits EXE/WB results to the register file, bypasses to ID reads,
// counts retirements and records every register write in a drop-on-full trace FIFO.
module wb_regfile_stage #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int TRACE_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_EXE_WB,
   input  logic              regwrite_EXE_WB,
   input  logic [ADDR_W-1:0] rd_EXE_WB,
   input  logic [DATA_W-1:0] aluout_EXE_WB,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic [31:0]       retire_count,
   output logic [7:0]        trace_drop_count,
   wb_regfile_stage_if.master trace
);
   localparam int NREG  = 1 << ADDR_W;
   localparam int PTR_W = $clog2(TRACE_DEPTH);
   localparam int CNT_W = $clog2(TRACE_DEPTH + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] val;
   } trace_t;

   logic              commit, wr, push, pop, push_ok;
   logic [DATA_W-1:0] regfile [NREG];
   trace_t            fifo    [TRACE_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;

   assign commit  = valid_EXE_WB;
   assign wr      = commit & regwrite_EXE_WB & (rd_EXE_WB != '0);
   assign full    = (count == CNT_W'(TRACE_DEPTH));
   assign push    = wr;
   assign pop     = trace.trace_valid & trace.trace_ready;
   // A pop in the same cycle frees the slot, so a push while full is still accepted.
   assign push_ok = push & (~full | pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regfile[i] <= '0;
      end else if (wr) begin
         regfile[rd_EXE_WB] <= aluout_EXE_WB;
      end
   end

   logic [1:0][ADDR_W-1:0] ra;
   assign ra = {rs2_addr, rs1_addr};

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [DATA_W-1:0] q;
      always_comb begin
         if (ra[p] == '0)                   q = '0;
         else if (wr && rd_EXE_WB == ra[p]) q = aluout_EXE_WB;
         else                               q = regfile[ra[p]];
      end
   end

   assign rs1_data = g_rd[0].q;
   assign rs2_data = g_rd[1].q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) retire_count <= '0;
      else if (commit) retire_count <= retire_count + 32'd1;
   end

   // TRACE_DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TRACE_DEPTH; i++) fifo[i] <= '0;
         rd_ptr           <= '0;
         wr_ptr           <= '0;
         count            <= '0;
         trace_drop_count <= '0;
      end else begin
         if (push_ok) begin
            fifo[wr_ptr] <= '{rd: rd_EXE_WB, val: aluout_EXE_WB};
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !push_ok && trace_drop_count != 8'hFF)
            trace_drop_count <= trace_drop_count + 8'd1;
      end
   end

   assign trace.trace_valid = (count != '0);
   assign trace.trace_full  = full;
   assign trace.trace_data  = fifo[rd_ptr];
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: bypass, r0, retire count, trace FIFO fill/drop/pop, async reset.
module tb_wb_regfile_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid_EXE_WB, regwrite_EXE_WB;
   logic [4:0]  rd_EXE_WB, rs1_addr, rs2_addr;
   logic [31:0] aluout_EXE_WB, rs1_data, rs2_data, retire_count;
   logic [7:0]  trace_drop_count;
   int          checks = 0;
   int          errors = 0;

   wb_regfile_stage_if #(.DATA_W(32), .ADDR_W(5)) tif ();

   wb_regfile_stage #(.DATA_W(32), .ADDR_W(5), .TRACE_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .valid_EXE_WB(valid_EXE_WB), .regwrite_EXE_WB(regwrite_EXE_WB),
      .rd_EXE_WB(rd_EXE_WB), .aluout_EXE_WB(aluout_EXE_WB),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .retire_count(retire_count), .trace_drop_count(trace_drop_count),
      .trace(tif.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] val);
      valid_EXE_WB    = v;
      regwrite_EXE_WB = rw;
      rd_EXE_WB       = rd;
      aluout_EXE_WB   = val;
   endtask

   // Advance one rising edge and land on the following falling edge.
   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0);
      rs1_addr = 5'd5;
      rs2_addr = 5'd0;
      tif.trace_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_retire", retire_count, 0);
      chk("rst_valid", tif.trace_valid, 0);
      chk("rst_full", tif.trace_full, 0);
      chk("rst_drop", trace_drop_count, 0);
      chk("rst_data", tif.trace_data, 0);
      chk("rst_rs1", rs1_data, 0);

      // Write rd=5 with same-cycle bypass
      drive(1, 1, 5, 32'hDEADBEEF);
      #1;
      chk("bypass_rs1", rs1_data, 32'hDEADBEEF);
      chk("pre_edge_valid", tif.trace_valid, 0);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("array_rs1", rs1_data, 32'hDEADBEEF);
      chk("retire_1", retire_count, 1);
      chk("trace_valid_1", tif.trace_valid, 1);
      chk("trace_head_1", tif.trace_data, {5'd5, 32'hDEADBEEF});
      tif.trace_ready = 1'b1;
      step();
      tif.trace_ready = 1'b0;
      #1;
      chk("drained", tif.trace_valid, 0);

      // r0 write: commits, counts, no push, reads zero
      drive(1, 1, 0, 32'h1234);
      #1;
      chk("r0_bypass", rs2_data, 0);
      step();
      // Commit without register write
      drive(1, 0, 7, 32'h55);
      rs2_addr = 5'd7;
      #1;
      chk("nowr_bypass", rs2_data, 0);
      step();
      // Invalid slot is ignored
      drive(0, 1, 7, 32'h66);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("r0_read", rs2_data, 0);
      chk("retire_3", retire_count, 3);
      chk("r0_no_push", tif.trace_valid, 0);

      // Back-to-back writes to the same register
      rs1_addr = 5'd9;
      drive(1, 1, 9, 32'hA);
      step();
      drive(1, 1, 9, 32'hB);
      #1;
      chk("b2b_bypass", rs1_data, 32'hB);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("b2b_array", rs1_data, 32'hB);
      chk("b2b_head", tif.trace_data, {5'd9, 32'hA});
      tif.trace_ready = 1'b1;
      repeat (2) step();
      tif.trace_ready = 1'b0;
      #1;
      chk("b2b_drained", tif.trace_valid, 0);

      // Fill: 6 writes into a 4-deep FIFO
      for (int i = 1; i <= 6; i++) begin
         drive(1, 1, 5'(i), 32'h100 + 32'(i));
         step();
      end
      drive(0, 0, 0, 0);
      rs1_addr = 5'd6;
      #1;
      chk("fill_full", tif.trace_full, 1);
      chk("fill_drop", trace_drop_count, 2);
      chk("fill_head", tif.trace_data, {5'd1, 32'h101});
      chk("dropped_still_written", rs1_data, 32'h106);
      chk("retire_11", retire_count, 11);

      // Push and pop together while full
      tif.trace_ready = 1'b1;
      drive(1, 1, 10, 32'hAAA);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("pp_full", tif.trace_full, 1);
      chk("pp_drop", trace_drop_count, 2);
      chk("pp_head", tif.trace_data, {5'd2, 32'h102});
      step();
      #1;
      chk("pop1_head", tif.trace_data, {5'd3, 32'h103});
      chk("pop1_full", tif.trace_full, 0);
      step();
      #1;
      chk("pop2_head", tif.trace_data, {5'd4, 32'h104});
      tif.trace_ready = 1'b0;
      step();
      tif.trace_ready = 1'b1;
      step();
      tif.trace_ready = 1'b0;
      #1;
      chk("pop3_head", tif.trace_data, {5'd10, 32'hAAA});
      chk("pop3_valid", tif.trace_valid, 1);

      // Queue 3 entries then reset between edges
      drive(1, 1, 5, 32'h555);
      step();
      drive(1, 1, 11, 32'hBBB);
      step();
      drive(0, 0, 0, 0);
      rs1_addr = 5'd5;
      #1;
      chk("pre_rst_rs1", rs1_data, 32'h555);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_valid", tif.trace_valid, 0);
      chk("arst_rs1", rs1_data, 0);
      chk("arst_retire", retire_count, 0);
      chk("arst_drop", trace_drop_count, 0);
      step();
      rst = 1'b1;
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("post_rst_retire", retire_count, 1);
      chk("post_rst_empty", tif.trace_valid, 0);

      // Drop counter saturates at 255
      for (int i = 0; i < 260; i++) begin
         drive(1, 1, 3, 32'(i));
         step();
      end
      drive(0, 0, 0, 0);
      #1;
      chk("sat_drop", trace_drop_count, 8'hFF);
      chk("sat_head", tif.trace_data, {5'd3, 32'd0});
      chk("sat_retire", retire_count, 261);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_regfile_stage.md
# wb_regfile_stage

Write-back stage of the 4-stage pipeline, directly downstream of the EXE/WB pipeline register that produces `aluout_EXE_WB`. It commits each valid EXE/WB result into a 32-entry architectural register file. It serves the ID stage's two combinational read ports with write-through bypass and counts retired instructions. It also pushes every register write into a small trace FIFO, which a debug consumer drains over a valid/ready handshake.

## Interface
- `DATA_W`, 32: register and result width
- `ADDR_W`, 5: register index width; register count is 2^ADDR_W
- `TRACE_DEPTH`, 4: trace FIFO entries; power of two, ≥2
- `clk` in 1: single clock, all state updates on the rising edge
- `rst` in 1: one clock; reset is asynchronous and active-low (`rst`=0 clears all state immediately)
- `valid_EXE_WB` in 1: the EXE/WB register holds a real instruction this cycle
- `regwrite_EXE_WB` in 1: that instruction writes a register
- `rd_EXE_WB` in ADDR_W: destination register index
- `aluout_EXE_WB` in DATA_W: result to commit
- `rs1_addr`, `rs2_addr` in ADDR_W: ID-stage read indices
- `rs1_data`, `rs2_data` out DATA_W: combinational read data
- `retire_count` out 32: count of valid commits
- `trace_valid` out 1: trace FIFO non-empty
- `trace_data` out ADDR_W+DATA_W: FIFO head, `{rd, value}`
- `trace_ready` in 1: consumer accepts the head this cycle
- `trace_full` out 1: FIFO holds TRACE_DEPTH entries
- `trace_drop_count` out 8: write events lost to a full FIFO, saturating

## Operation
- Commit: `commit` = `valid_EXE_WB`. Write event `wr` = `commit & regwrite_EXE_WB & (rd_EXE_WB != 0)`.
- On `wr`, `regfile[rd_EXE_WB]` <= `aluout_EXE_WB` at the rising edge. Register 0 is never written and always reads 0.
- Read port, identical for rs1 and rs2:
  - addr==0 → 0.
  - Else if `wr` and rd==addr → `aluout_EXE_WB` (bypass).
  - Else → `regfile[addr]`.
- `retire_count` increments by 1 per `commit`, including commits with no register write and writes to r0. It wraps 0xFFFFFFFF→0.
- Trace FIFO: circular buffer with read/write pointers and an occupancy count 0..TRACE_DEPTH.
  - `push` = `wr`, with data `{rd_EXE_WB, aluout_EXE_WB}`.
  - `pop` = `trace_valid & trace_ready`.
  - `trace_valid` = count!=0. `trace_full` = count==TRACE_DEPTH. `trace_data` = entry at the read pointer.
  - Pointers wrap modulo TRACE_DEPTH.
  - Push while full with no pop: the entry is dropped, FIFO contents are unchanged, and `trace_drop_count` increments, holding at 255.
  - Push and pop in the same cycle while full: the pop frees a slot, the push is accepted, and count stays TRACE_DEPTH with no drop.
  - Push and pop in the same cycle while empty is impossible, because pop requires `trace_valid`.
- The trace FIFO never back-pressures the pipeline. Write-back always commits.
- `trace_ready` while empty has no effect.
- Inputs with `valid_EXE_WB`=0 are ignored entirely.

## Timing
- Reset values, applied asynchronously while `rst`=0:
  - all registers 0
  - `retire_count` 0
  - FIFO empty: `trace_valid` 0, `trace_full` 0, `trace_drop_count` 0
  - `trace_data` 0
  - `rs1_data`/`rs2_data` 0 (purely combinational from the cleared array)
- Reset asserted mid-operation discards every pending commit and FIFO entry immediately. The first commit after deassertion is counted as retire 1.
- Read data is combinational, with zero-cycle visibility of the committing result through the bypass. The array holds the value from the edge following the commit.
- Counters and FIFO outputs change only at rising edges. `trace_valid` rises the cycle after the commit edge that pushed into an empty FIFO. A popped entry leaves at the edge where `pop` is sampled.
- Back-to-back commits are supported every cycle. Two commits to the same rd in consecutive cycles must be read as the newer value in the second cycle.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, release → `retire_count`=0, `trace_valid`=0, `rs1_data` for addr 5 = 0.
- Write/bypass: commit rd=5, value 0xDEADBEEF with `rs1_addr`=5 in the same cycle → `rs1_data`=0xDEADBEEF in that cycle and the next. `retire_count`=1.
- r0 protection: commit rd=0, value 0x1234, regwrite=1 → `rs2_data`(addr 0)=0, no trace push, `retire_count` increments.
- FIFO fill/drop: `trace_ready`=0, 6 write commits with TRACE_DEPTH=4 → `trace_full`=1, `trace_drop_count`=2, head is the first write's `{rd, value}`.
- Simultaneous push/pop while full: `trace_ready`=1 plus a new write → count stays 4, drop count unchanged, and the 5th-accepted entry appears at the tail after 3 further pops.
- Async reset mid-stream: pull `rst` low between edges with 3 FIFO entries queued → `trace_valid` drops to 0 before the next edge, and register 5 reads 0.
